// File: rtl/prescalador_multicanal.sv
// rtl/prescalador_multicanal.sv - multichannel programmable tick/square-wave prescaler
module prescalador_multicanal #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 20,
    parameter int DEFAULT_LIM = 416666,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_sync,
    input  logic [CHANNELS-1:0] i_ch_en,
    input  logic                i_wr,
    input  logic [CH_W-1:0]     i_wr_ch,
    input  logic [WIDTH-1:0]    i_wr_lim,
    input  logic                i_wr_mode,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_wave,
    output logic [CHANNELS-1:0] o_armed
);

    localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(DEFAULT_LIM);

    logic [WIDTH-1:0]    cnt        [CHANNELS];
    logic [WIDTH-1:0]    active_lim [CHANNELS];
    logic [WIDTH-1:0]    shadow_lim [CHANNELS];
    logic [CHANNELS-1:0] mode;

    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] hit;

    // Per-channel run/terminal/write-select decode; an out-of-range i_wr_ch matches no channel
    always_comb begin
        run  = '0;
        term = '0;
        hit  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            run[c]  = i_ch_en[c] & o_armed[c];
            term[c] = run[c] && (cnt[c] == active_lim[c]);
            hit[c]  = i_wr && (32'(i_wr_ch) == c);
        end
    end

    // Counter, limit, mode and output registers for every channel
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c]        <= '0;
                active_lim[c] <= LIM_RST;
                shadow_lim[c] <= LIM_RST;
            end
            mode    <= '0;
            o_tick  <= '0;
            o_wave  <= '0;
            o_armed <= '1;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                // Configuration always lands in the shadow copy, even during a restart
                if (hit[c]) begin
                    shadow_lim[c] <= i_wr_lim;
                    mode[c]       <= i_wr_mode;
                end

                if (i_sync) begin
                    // Restart begins a fresh period, so a coincident write can take effect at once
                    cnt[c]     <= '0;
                    o_tick[c]  <= 1'b0;
                    o_wave[c]  <= 1'b0;
                    o_armed[c] <= 1'b1;
                    if (hit[c]) begin
                        active_lim[c] <= i_wr_lim;
                    end
                end else if (term[c]) begin
                    // End of period: a same-cycle write is forwarded so the stale shadow is never used
                    cnt[c]        <= '0;
                    o_tick[c]     <= 1'b1;
                    o_wave[c]     <= ~o_wave[c];
                    active_lim[c] <= hit[c] ? i_wr_lim : shadow_lim[c];
                    o_armed[c]    <= ~(hit[c] ? i_wr_mode : mode[c]);
                end else begin
                    o_tick[c] <= 1'b0;
                    if (run[c]) begin
                        cnt[c] <= cnt[c] + WIDTH'(1);
                    end else if (hit[c]) begin
                        // Idle channel: no period in progress, so apply the new limit and restart
                        active_lim[c] <= i_wr_lim;
                        cnt[c]        <= '0;
                        o_armed[c]    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_prescalador_multicanal.sv
// tb/tb_prescalador_multicanal.sv - scoreboard bench for prescalador_multicanal
module tb_prescalador_multicanal;

    typedef struct {
        int         cyc;
        int         tag;
        logic [3:0] tick;
        logic [3:0] wave;
        logic [3:0] armed;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sync;
    logic [3:0] en4;
    logic       wr4;
    logic [1:0] wr4_ch;
    logic [7:0] wr4_lim;
    logic       wr4_mode;
    logic [3:0] t4, w4, a4;

    logic [2:0] en3;
    logic       wr3;
    logic [1:0] wr3_ch;
    logic [7:0] wr3_lim;
    logic       wr3_mode;
    logic [2:0] t3, w3, a3;

    int   cyc    = 0;
    int   base   = 0;
    int   tag    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q4[$];
    exp_t q3[$];

    prescalador_multicanal #(.CHANNELS(4), .WIDTH(8), .DEFAULT_LIM(20)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_sync(sync), .i_ch_en(en4),
        .i_wr(wr4), .i_wr_ch(wr4_ch), .i_wr_lim(wr4_lim), .i_wr_mode(wr4_mode),
        .o_tick(t4), .o_wave(w4), .o_armed(a4)
    );

    prescalador_multicanal #(.CHANNELS(3), .WIDTH(8), .DEFAULT_LIM(5)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_sync(sync), .i_ch_en(en3),
        .i_wr(wr3), .i_wr_ch(wr3_ch), .i_wr_lim(wr3_lim), .i_wr_mode(wr3_mode),
        .o_tick(t3), .o_wave(w3), .o_armed(a3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic judge(input string who, input exp_t e,
                         input logic [3:0] t, input logic [3:0] w, input logic [3:0] a);
        n_cmp++;
        if ({t, w, a} !== {e.tick, e.wave, e.armed}) begin
            n_fail++;
            $display("FAIL %s t%0d cyc %0d: got tick=%b wave=%b armed=%b, want tick=%b wave=%b armed=%b",
                     who, e.tag, cyc, t, w, a, e.tick, e.wave, e.armed);
        end
    endtask

    // Monitor: pops an expectation when its cycle arrives; any other tick is unexpected
    always @(negedge clk) begin
        exp_t e;
        while (q4.size() > 0 && q4[0].cyc < cyc) begin
            e = q4.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL sb4 t%0d: check for cycle %0d never reached (now %0d)", e.tag, e.cyc, cyc);
        end
        if (q4.size() > 0 && q4[0].cyc == cyc) begin
            e = q4.pop_front();
            judge("sb4", e, t4, w4, a4);
        end else if (t4 != 4'b0000) begin
            n_cmp++; n_fail++;
            $display("FAIL sb4 t%0d cyc %0d: unexpected tick=%b, want 0000", tag, cyc, t4);
        end

        while (q3.size() > 0 && q3[0].cyc < cyc) begin
            e = q3.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL sb3 t%0d: check for cycle %0d never reached (now %0d)", e.tag, e.cyc, cyc);
        end
        if (q3.size() > 0 && q3[0].cyc == cyc) begin
            e = q3.pop_front();
            judge("sb3", e, {1'b0, t3}, {1'b0, w3}, {1'b0, a3});
        end else if (t3 != 3'b000) begin
            n_cmp++; n_fail++;
            $display("FAIL sb3 t%0d cyc %0d: unexpected tick=%b, want 000", tag, cyc, t3);
        end
    end

    task automatic push4(input int d, input logic [3:0] t, input logic [3:0] w, input logic [3:0] a);
        q4.push_back('{base + d, tag, t, w, a});
    endtask

    task automatic push3(input int d, input logic [3:0] t, input logic [3:0] w, input logic [3:0] a);
        q3.push_back('{base + d, tag, t, w, a});
    endtask

    task automatic mark();
        base = cyc;
    endtask

    task automatic goto(input int d);
        while (cyc < base + d) @(negedge clk);
    endtask

    task automatic w4_set(input logic [1:0] ch, input logic [7:0] lim, input logic md);
        wr4 = 1'b1; wr4_ch = ch; wr4_lim = lim; wr4_mode = md;
    endtask

    task automatic w3_set(input logic [1:0] ch, input logic [7:0] lim, input logic md);
        wr3 = 1'b1; wr3_ch = ch; wr3_lim = lim; wr3_mode = md;
    endtask

    task automatic clear();
        mark();
        sync = 1'b1; en4 = 4'b0000; en3 = 3'b000;
        push4(1, 4'b0000, 4'b0000, 4'b1111);
        push3(1, 4'b0000, 4'b0000, 4'b0111);
        goto(1);
        sync = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; en4 = '0; en3 = '0;
        wr4 = 1'b0; wr4_ch = '0; wr4_lim = '0; wr4_mode = 1'b0;
        wr3 = 1'b0; wr3_ch = '0; wr3_lim = '0; wr3_mode = 1'b0;

        // Reset state
        tag = 0; mark();
        push4(2, 4'b0000, 4'b0000, 4'b1111);
        push3(2, 4'b0000, 4'b0000, 4'b0111);
        goto(2);
        rst = 1'b0;

        // Channel 0, lim 4: ticks 5/10/15 cycles after enable
        tag = 1; mark();
        w4_set(2'd0, 8'd4, 1'b0);
        goto(1); wr4 = 1'b0; en4 = 4'b0001; mark();
        push4(5,  4'b0001, 4'b0001, 4'b1111);
        push4(10, 4'b0001, 4'b0000, 4'b1111);
        push4(15, 4'b0001, 4'b0001, 4'b1111);
        goto(16); en4 = 4'b0000;
        goto(17); clear();

        // Channel 1, lim 9, rewritten to 2 mid-period
        tag = 2; mark();
        w4_set(2'd1, 8'd9, 1'b0);
        goto(1); wr4 = 1'b0; en4 = 4'b0010; mark();
        push4(10, 4'b0010, 4'b0010, 4'b1111);
        push4(20, 4'b0010, 4'b0000, 4'b1111);
        push4(23, 4'b0010, 4'b0010, 4'b1111);
        push4(26, 4'b0010, 4'b0000, 4'b1111);
        goto(13); w4_set(2'd1, 8'd2, 1'b0);
        goto(14); wr4 = 1'b0;
        goto(27); en4 = 4'b0000;
        goto(28); clear();

        // Channel 2 one-shot, then re-armed by a rewrite
        tag = 3; mark();
        w4_set(2'd2, 8'd3, 1'b1);
        goto(1); wr4 = 1'b0; en4 = 4'b0100; mark();
        push4(4,  4'b0100, 4'b0100, 4'b1011);
        push4(8,  4'b0000, 4'b0100, 4'b1011);
        push4(10, 4'b0000, 4'b0100, 4'b1111);
        push4(14, 4'b0100, 4'b0000, 4'b1011);
        push4(20, 4'b0000, 4'b0000, 4'b1011);
        goto(9);  w4_set(2'd2, 8'd3, 1'b1);
        goto(10); wr4 = 1'b0;
        goto(20); clear();

        // Channel 3, lim 0: tick every cycle, wave holds once disabled
        tag = 4; mark();
        w4_set(2'd3, 8'd0, 1'b0);
        goto(1); wr4 = 1'b0; en4 = 4'b1000; mark();
        for (int d = 1; d <= 5; d++)
            push4(d, 4'b1000, (d % 2 == 1) ? 4'b1000 : 4'b0000, 4'b1111);
        push4(7, 4'b0000, 4'b1000, 4'b1111);
        push4(9, 4'b0000, 4'b1000, 4'b1111);
        goto(5); en4 = 4'b0000;
        goto(9); clear();

        // All channels, sync with coincident write, then reset mid-count
        tag = 5; mark();
        w4_set(2'd0, 8'd2, 1'b0);
        goto(1); w4_set(2'd1, 8'd4, 1'b0);
        goto(2); w4_set(2'd2, 8'd6, 1'b0);
        goto(3); w4_set(2'd3, 8'd8, 1'b0);
        goto(4); wr4 = 1'b0; en4 = 4'b1111; mark();
        push4(3,  4'b0001, 4'b0001, 4'b1111);
        push4(5,  4'b0010, 4'b0011, 4'b1111);
        push4(6,  4'b0001, 4'b0010, 4'b1111);
        push4(7,  4'b0100, 4'b0110, 4'b1111);
        push4(8,  4'b0000, 4'b0000, 4'b1111);
        push4(10, 4'b1000, 4'b1000, 4'b0111);
        push4(11, 4'b0001, 4'b1001, 4'b0111);
        push4(13, 4'b0010, 4'b1011, 4'b0111);
        push4(14, 4'b0001, 4'b1010, 4'b0111);
        push4(15, 4'b0100, 4'b1110, 4'b0111);
        push4(16, 4'b0000, 4'b0000, 4'b1111);
        push3(16, 4'b0000, 4'b0000, 4'b0111);
        push4(37, 4'b1111, 4'b1111, 4'b1111);
        goto(7);  sync = 1'b1; w4_set(2'd3, 8'd1, 1'b1);
        goto(8);  sync = 1'b0; wr4 = 1'b0;
        goto(15); rst = 1'b1;
        goto(16); rst = 1'b0;
        goto(37); en4 = 4'b0000;
        goto(38);

        // Three-channel build: out-of-range write ignored, defaults still in force
        tag = 6; mark();
        w3_set(2'd3, 8'd1, 1'b1);
        goto(1); wr3 = 1'b0; en3 = 3'b111; mark();
        push3(6, 4'b0111, 4'b0111, 4'b0111);
        goto(6); en3 = 3'b000;
        goto(7); clear();

        // Write coinciding with terminal count on channel 0
        tag = 7; mark();
        en3 = 3'b001;
        push3(6,  4'b0001, 4'b0001, 4'b0111);
        push3(9,  4'b0001, 4'b0000, 4'b0111);
        push3(12, 4'b0001, 4'b0001, 4'b0110);
        push3(16, 4'b0000, 4'b0001, 4'b0110);
        goto(5);  w3_set(2'd0, 8'd2, 1'b0);
        goto(6);  wr3 = 1'b0;
        goto(11); w3_set(2'd0, 8'd2, 1'b1);
        goto(12); wr3 = 1'b0;
        goto(16); en3 = 3'b000;
        goto(18);

        while (q4.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb4 t%0d: check for cycle %0d left unchecked", q4[0].tag, q4[0].cyc);
            void'(q4.pop_front());
        end
        while (q3.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb3 t%0d: check for cycle %0d left unchecked", q3[0].tag, q3[0].cyc);
            void'(q3.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
